// File: rtl/comma_aligner.sv
// Receive word aligner: hunts for K28.5 in either disparity, sets the 10-bit
// symbol boundary with HUNT/VERIFY/LOCKED hysteresis and strobes out aligned symbols.
module comma_aligner #(
    parameter int LOCK_COUNT   = 3,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic       BitCLK,
    input  logic       Reset,
    input  logic       Serial,
    output logic [9:0] RxParallel_10,
    output logic       symbol_valid,
    output logic       aligned,
    output logic       comma_detected,
    output logic       realigned
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] K28P5_RDN = 10'b0011111010;
    localparam logic [9:0] K28P5_RDP = 10'b1100000101;
    localparam logic [3:0] LOCK_TH   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_TH = 4'(UNLOCK_COUNT);

    logic [9:0] window_q, window_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] good_cnt_q, good_cnt_d;
    logic [3:0] bad_cnt_q, bad_cnt_d;
    state_t     state_q, state_d;
    logic [9:0] rx_q, rx_d;
    logic       valid_q, valid_d;
    logic       aligned_q, aligned_d;
    logic       comma_q, comma_d;
    logic       realigned_q, realigned_d;

    logic       is_comma;
    logic       on_boundary;
    logic       establish;
    logic [3:0] good_inc;
    logic [3:0] bad_inc;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    always_comb begin
        is_comma    = (window_q == K28P5_RDN) || (window_q == K28P5_RDP);
        on_boundary = (state_q != ST_HUNT) && (bit_cnt_q == 4'd9);
        good_inc    = sat_inc(good_cnt_q);
        bad_inc     = sat_inc(bad_cnt_q);

        window_d    = {window_q[8:0], Serial};
        bit_cnt_d   = (bit_cnt_q == 4'd9) ? 4'd0 : bit_cnt_q + 4'd1;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        state_d     = state_q;
        realigned_d = 1'b0;
        establish   = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (is_comma) begin
                    establish = 1'b1;
                end
            end
            ST_VERIFY: begin
                if (is_comma) begin
                    if (on_boundary) begin
                        good_cnt_d = good_inc;
                        if (good_inc >= LOCK_TH) begin
                            state_d   = ST_LOCKED;
                            bad_cnt_d = 4'd0;
                        end
                    end else begin
                        establish = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                // Stray commas only move the boundary once enough arrive in a row
                if (is_comma) begin
                    if (on_boundary) begin
                        bad_cnt_d = 4'd0;
                    end else if (bad_inc >= UNLOCK_TH) begin
                        establish = 1'b1;
                        bad_cnt_d = 4'd0;
                    end else begin
                        bad_cnt_d = bad_inc;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase

        if (establish) begin
            bit_cnt_d   = 4'd0;
            good_cnt_d  = 4'd1;
            realigned_d = 1'b1;
            if (state_q == ST_LOCKED) begin
                state_d = ST_VERIFY;
            end else if (LOCK_COUNT == 1) begin
                state_d = ST_LOCKED;
            end else begin
                state_d = ST_VERIFY;
            end
        end

        // The comma that (re)establishes the boundary is itself emitted as a symbol
        valid_d   = on_boundary || establish;
        rx_d      = valid_d ? window_q : rx_q;
        aligned_d = (state_d == ST_LOCKED);
        comma_d   = is_comma;
    end

    always_ff @(posedge BitCLK or posedge Reset) begin
        if (Reset) begin
            window_q    <= '0;
            bit_cnt_q   <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            state_q     <= ST_HUNT;
            rx_q        <= '0;
            valid_q     <= 1'b0;
            aligned_q   <= 1'b0;
            comma_q     <= 1'b0;
            realigned_q <= 1'b0;
        end else begin
            window_q    <= window_d;
            bit_cnt_q   <= bit_cnt_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            state_q     <= state_d;
            rx_q        <= rx_d;
            valid_q     <= valid_d;
            aligned_q   <= aligned_d;
            comma_q     <= comma_d;
            realigned_q <= realigned_d;
        end
    end

    assign RxParallel_10  = rx_q;
    assign symbol_valid   = valid_q;
    assign aligned        = aligned_q;
    assign comma_detected = comma_q;
    assign realigned      = realigned_q;

endmodule

// File: doc/comma_aligner.md
Name: comma_aligner

Overview:
Receive-side word aligner placed directly after the serial sampler and in front of the elastic buffer. It shifts the recovered serial bitstream into a 10-bit window and hunts for the K28.5 comma in either running disparity. It then establishes and maintains the 10-bit symbol boundary and emits aligned 10-bit symbols with a one-cycle strobe every 10 bit clocks. A hysteresis state machine (HUNT / VERIFY / LOCKED) keeps single stray commas from moving an established boundary.

Parameters:
LOCK_COUNT, 3, consecutive boundary-aligned commas, counting the one that set the boundary, needed to go VERIFY -> LOCKED (range 1..15).
UNLOCK_COUNT, 4, consecutive misaligned commas in LOCKED that force a realignment (range 1..15).

Ports:
BitCLK  input  1  bit-rate clock; all state updates on its rising edge.
Reset  input  1  asynchronous, active-high reset.
Serial  input  1  recovered serial data bit, one per BitCLK.
RxParallel_10  output  10  aligned symbol; bit 9 = first-received bit (a), bit 0 = last (j).
symbol_valid  output  1  one-cycle strobe: RxParallel_10 holds a new aligned symbol.
aligned  output  1  high while the state is LOCKED.
comma_detected  output  1  one-cycle pulse for any comma in the window, aligned or not.
realigned  output  1  one-cycle pulse whenever the symbol boundary is (re)established.

Behaviour:
- Reset (async, active-high): window=0, bit_cnt=0, good_cnt=0, bad_cnt=0, state=HUNT. All outputs are 0.
- Window: every edge, window <= {window[8:0], Serial}, so window[9] is the oldest bit.
- Comma: window==10'b0011111010 (K28.5 RD-) or 10'b1100000101 (RD+). Evaluated on the registered window each cycle.
- Boundary cycle: a cycle where the window holds a complete aligned symbol.
  - bit_cnt (0..9) increments each cycle and wraps 9->0.
  - A boundary is bit_cnt==9 while in VERIFY or LOCKED.
  - Establishing a boundary makes the current cycle a boundary and loads bit_cnt=0 at the next edge.
- Output:
  - At the edge ending a boundary cycle: RxParallel_10 <= window and symbol_valid=1 for exactly the next cycle.
  - Latency: last bit of a symbol sampled at edge k -> symbol on RxParallel_10 and symbol_valid high after edge k+1.
  - RxParallel_10 holds its value between strobes.
  - HUNT produces no strobes.
- Aligned comma = comma on a boundary cycle. Misaligned comma = comma on a non-boundary cycle.
- HUNT:
  - Any comma establishes a boundary, sets good_cnt=1, pulses realigned.
  - Next state is VERIFY, or LOCKED directly if LOCK_COUNT==1.
- VERIFY:
  - Aligned comma: good_cnt++. Reaching LOCK_COUNT -> LOCKED and aligned=1 from the next cycle.
  - Misaligned comma: re-establish the boundary at that comma, good_cnt=1, pulse realigned, stay in VERIFY.
  - Non-comma symbols do not change good_cnt.
- LOCKED:
  - Aligned comma: bad_cnt=0.
  - Misaligned comma: bad_cnt++ and the boundary is unchanged.
  - Non-comma symbols leave bad_cnt unchanged.
  - When bad_cnt reaches UNLOCK_COUNT: re-establish the boundary at that comma, good_cnt=1, bad_cnt=0, pulse realigned, aligned=0 next cycle, go to VERIFY.
- comma_detected is registered: high the cycle after the window holds a comma, in every state.
- Simultaneous events:
  - A comma on the cycle that reaches a count threshold is handled by a single transition in that cycle.
  - Realignment on a cycle that would have been a boundary still emits exactly one strobe for that window.
- Reset mid-operation: immediate return to reset values. The first comma after deassertion is treated as a HUNT comma.
- Counters saturate at 15. No arithmetic overflow is possible.

Test Plan:
1. Reset held 5 cycles with random Serial -> all outputs 0, no strobes. Release, feed 37 random non-comma bits -> symbol_valid stays 0.
2. Feed 3 random bits, then K28.5 RD- (0011111010) -> realigned and comma_detected pulse, RxParallel_10=0x0FA with symbol_valid exactly 2 cycles after the last comma bit; strobes every 10 cycles after that.
3. After step 2, send two more aligned commas alternating RD+ (0x305) and RD- among data symbols -> aligned rises the cycle after the 3rd comma's boundary edge. Data symbols are output unshifted.
4. LOCKED, inject 3 commas at a +4-bit offset separated by aligned data -> boundary unchanged, aligned stays 1. An aligned comma then clears the count; 4 consecutive offset commas -> realigned pulse, aligned=0, strobes move to the new phase.
5. VERIFY with good_cnt=2, inject a misaligned comma -> immediate realign, good_cnt restarts. LOCKED needs 2 more aligned commas at the new phase.
6. Assert Reset for 1 cycle mid-symbol while LOCKED -> outputs 0 immediately. After release, no strobes until a fresh comma; alignment then follows the new comma's phase.
